// File: rtl/conv_pkg.sv
// Shared defaults, types and helper functions for the conv engine blocks.
package conv_pkg;

    localparam int DW_DEF    = 8;
    localparam int KSIZE_DEF = 3;
    localparam int NCH_DEF   = 4;

    function automatic int taps_of(input int ksize);
        return ksize * ksize;
    endfunction

    // Never returns 0, so a one-entry dimension still gets a 1-bit index.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } seq_state_t;

endpackage

// File: rtl/conv_weight_rf.sv
// NCH x TAPS weight register file: one range-checked write port, combinational read.
// With CONV_WSEQ_ZERO_SKIP_EN defined it also exports a per-tap nonzero mask of the read kernel.
module conv_weight_rf
    import conv_pkg::*;
#(
    parameter  int DW   = DW_DEF,
    parameter  int NCH  = NCH_DEF,
    parameter  int TAPS = taps_of(KSIZE_DEF),
    localparam int CW   = clog2(NCH),
    localparam int TW   = clog2(TAPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_ch,
    input  logic [TW-1:0] wr_tap,
    input  logic [DW-1:0] wr_data,
    output logic          wr_err,
    input  logic [CW-1:0] rd_ch,
    input  logic [TW-1:0] rd_tap,
    output logic [DW-1:0] rd_data
`ifdef CONV_WSEQ_ZERO_SKIP_EN
    ,
    output logic [TAPS-1:0] rd_nz
`endif
);

    localparam logic [CW:0] NCH_L  = (CW + 1)'(NCH);
    localparam logic [TW:0] TAPS_L = (TW + 1)'(TAPS);

    logic [DW-1:0] mem [NCH][TAPS];
    logic          wr_ok;

    assign wr_ok  = ({1'b0, wr_ch} < NCH_L) && ({1'b0, wr_tap} < TAPS_L);
    assign wr_err = wr_en && !wr_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                for (int t = 0; t < TAPS; t++) begin
                    mem[c][t] <= '0;
                end
            end
        end else if (wr_en && wr_ok) begin
            mem[wr_ch][wr_tap] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ch][rd_tap];

`ifdef CONV_WSEQ_ZERO_SKIP_EN
    always_comb begin
        rd_nz = '0;
        for (int t = 0; t < TAPS; t++) begin
            rd_nz[t] = |mem[rd_ch][t];
        end
    end
`endif

endmodule

// File: rtl/conv_weight_seq.sv
// Weight store and tap sequencer for the serial KxK conv engine.
// Optional zero-weight skipping is enabled by defining CONV_WSEQ_ZERO_SKIP_EN.
//
// state  | meaning
// IDLE   | waiting for start; writes and rejected requests still handled
// STREAM | presenting kernel act_ch tap cnt to the MAC
module conv_weight_seq
    import conv_pkg::*;
#(
    parameter  int DW    = DW_DEF,
    parameter  int KSIZE = KSIZE_DEF,
    parameter  int NCH   = NCH_DEF,
    localparam int TAPS  = taps_of(KSIZE),
    localparam int CW    = clog2(NCH),
    localparam int TW    = clog2(TAPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_ch,
    input  logic [TW-1:0] wr_tap,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    input  logic [CW-1:0] ch_sel,
    output logic          w_valid,
    input  logic          w_ready,
    output logic [DW-1:0] w_data,
    output logic [TW-1:0] w_tap,
    output logic          w_last,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [CW:0]   NCH_L    = (CW + 1)'(NCH);
    localparam logic [TW-1:0] LAST_TAP = TW'(TAPS - 1);

    seq_state_t    state, state_nxt;
    logic [TW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] act_ch, act_ch_nxt;
    logic          done_nxt, err_nxt;
    logic          wr_err;
    logic [DW-1:0] rd_data;
    logic          beat_ok;
    logic          last_beat;

`ifdef CONV_WSEQ_ZERO_SKIP_EN
    logic [TAPS-1:0] rd_nz;
    logic            hi_nz;
`endif

    conv_weight_rf #(
        .DW   (DW),
        .NCH  (NCH),
        .TAPS (TAPS)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_tap  (wr_tap),
        .wr_data (wr_data),
        .wr_err  (wr_err),
        .rd_ch   (act_ch),
        .rd_tap  (cnt),
        .rd_data (rd_data)
`ifdef CONV_WSEQ_ZERO_SKIP_EN
        ,
        .rd_nz   (rd_nz)
`endif
    );

`ifdef CONV_WSEQ_ZERO_SKIP_EN
    // A beat is last when no nonzero weight sits above the current tap.
    always_comb begin
        hi_nz = 1'b0;
        for (int t = 0; t < TAPS; t++) begin
            if (TW'(t) > cnt) hi_nz = hi_nz | rd_nz[t];
        end
    end

    assign beat_ok   = |rd_data;
    assign last_beat = !hi_nz;
`else
    assign beat_ok   = 1'b1;
    assign last_beat = (cnt == LAST_TAP);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            act_ch <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            act_ch <= act_ch_nxt;
            done   <= done_nxt;
            err    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        act_ch_nxt = act_ch;
        done_nxt   = 1'b0;
        err_nxt    = wr_err;
        case (state)
            IDLE: begin
                if (start) begin
                    if ({1'b0, ch_sel} < NCH_L) begin
                        state_nxt  = STREAM;
                        act_ch_nxt = ch_sel;
                        cnt_nxt    = '0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            STREAM: begin
                // Skipped (zero) taps advance without waiting for the MAC.
                if (w_ready || !beat_ok) begin
                    if (cnt == LAST_TAP) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + TW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy    = (state == STREAM);
    assign w_valid = busy && beat_ok;
    assign w_data  = w_valid ? rd_data : '0;
    assign w_tap   = w_valid ? cnt : '0;
    assign w_last  = w_valid && last_beat;

endmodule

// File: tb/tb_conv_weight_seq.sv
// Self-checking bench for conv_weight_seq against a kernel-level reference model.
module tb_conv_weight_seq;

    localparam int NCH  = 4;
    localparam int TAPS = 9;

    typedef struct {
        int ch;
        int tap;
        int data;
    } wr_t;

    logic       clk;
    logic       rst_n, wr_en, start, w_ready;
    logic [1:0] wr_ch, ch_sel;
    logic [3:0] wr_tap;
    logic [7:0] wr_data;
    logic       w_valid, w_last, busy, done, err;
    logic [7:0] w_data;
    logic [3:0] w_tap;

    logic       start3, wr_en3;
    logic [1:0] ch_sel3, wr_ch3;
    logic [3:0] wr_tap3;
    logic [7:0] wr_data3;
    logic       w_valid3, w_last3, busy3, done3, err3;
    logic [7:0] w_data3;
    logic [3:0] w_tap3;

    int n_cmp = 0;
    int n_err = 0;

    int  mdl [NCH][TAPS];
    int  exp_q[$];
    int  bq_tap[$], bq_data[$], bq_exp[$], bq_cyc[$];
    bit  bq_last[$];
    int  sq_tap[$], sq_data[$];
    wr_t inj_q[$];
    bit  err_seen;

    conv_weight_seq u_dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_tap(wr_tap), .wr_data(wr_data),
        .start(start), .ch_sel(ch_sel),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_tap(w_tap),
        .w_last(w_last), .busy(busy), .done(done), .err(err)
    );

    // Three-kernel instance: the only way to present an out-of-range channel code.
    conv_weight_seq #(.NCH(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en3), .wr_ch(wr_ch3), .wr_tap(wr_tap3), .wr_data(wr_data3),
        .start(start3), .ch_sel(ch_sel3),
        .w_valid(w_valid3), .w_ready(1'b1), .w_data(w_data3), .w_tap(w_tap3),
        .w_last(w_last3), .busy(busy3), .done(done3), .err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit emits(input int v);
`ifdef CONV_WSEQ_ZERO_SKIP_EN
        return v != 0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic void build_exp(input int ch);
        exp_q.delete();
        for (int t = 0; t < TAPS; t++) if (emits(mdl[ch][t])) exp_q.push_back(t);
    endfunction

    function automatic void clear_model();
        for (int c = 0; c < NCH; c++) for (int t = 0; t < TAPS; t++) mdl[c][t] = 0;
    endfunction

    task automatic write_w(input int ch, input int tap, input int data, output bit e);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_ch = 2'(ch); wr_tap = 4'(tap); wr_data = 8'(data);
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(negedge clk);
        e = err;
        if (ch < NCH && tap < TAPS) mdl[ch][tap] = data;
    endtask

    // Drives one stream and records what the MAC side sees; rmode 0=ready, 1=random, 2=stall.
    task automatic run_stream(input int ch, input int rmode, input int stall_tap, input int stall_len,
                              input int inj_tap, input int poke_cyc, output int n_done, output int n_busy);
        wr_t pend;
        bit  pend_v, inj_on;
        int  stalled;
        bq_tap.delete(); bq_data.delete(); bq_exp.delete(); bq_cyc.delete(); bq_last.delete();
        sq_tap.delete(); sq_data.delete();
        err_seen = 0; n_done = -1; n_busy = 0; pend_v = 0; inj_on = 0; stalled = 0;
        @(posedge clk); #1;
        start = 1'b1; ch_sel = 2'(ch);
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            start = 1'b0; wr_en = 1'b0;
            if (pend_v) begin mdl[pend.ch][pend.tap] = pend.data; pend_v = 0; end
            if (n == poke_cyc) begin start = 1'b1; ch_sel = 2'(ch + 1); end
            if (w_valid && w_tap == 4'(inj_tap)) inj_on = 1;
            if (inj_on && inj_q.size() > 0) begin
                pend = inj_q.pop_front(); pend_v = 1;
                wr_en = 1'b1; wr_ch = 2'(pend.ch); wr_tap = 4'(pend.tap); wr_data = 8'(pend.data);
            end
            if (rmode == 1) w_ready = 1'($urandom_range(0, 1));
            else w_ready = 1'b1;
            if (rmode == 2 && w_valid && w_tap == 4'(stall_tap) && stalled < stall_len) begin
                w_ready = 1'b0; stalled++;
                sq_tap.push_back(int'(w_tap)); sq_data.push_back(int'(w_data));
            end
            @(negedge clk);
            if (err) err_seen = 1;
            if (busy) n_busy++;
            if (w_valid && w_ready) begin
                bq_tap.push_back(int'(w_tap)); bq_data.push_back(int'(w_data));
                bq_last.push_back(w_last); bq_cyc.push_back(n);
                bq_exp.push_back(int'(w_tap) < TAPS ? mdl[ch][w_tap] : -1);
            end
            if (done) begin n_done = n; break; end
        end
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0; w_ready = 1'b1;
        if (pend_v) mdl[pend.ch][pend.tap] = pend.data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_model();
        @(negedge clk);
        n_cmp++;
        if ({w_valid, w_last, busy, done, err, w_data, w_tap} !== 17'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, expected 0", {w_valid, w_last, busy, done, err, w_data, w_tap});
        end
        n_cmp++;
        if ({w_valid3, w_last3, busy3, done3, err3, w_data3, w_tap3} !== 17'h0) begin
            n_err++;
            $display("FAIL reset_outputs3: got %h, expected 0", {w_valid3, w_last3, busy3, done3, err3, w_data3, w_tap3});
        end
    endtask

    task automatic test_load();
        bit e;
        int errs = 0;
        for (int c = 0; c < NCH; c++)
            for (int t = 0; t < TAPS; t++) begin
                write_w(c, t, 16 * c + t + 1, e);
                if (e) errs++;
            end
        n_cmp++;
        if (errs !== 0) begin n_err++; $display("FAIL load_err: got %0d err pulses, expected 0", errs); end
    endtask

    task automatic test_stream();
        int nd, nb;
        build_exp(2);
        run_stream(2, 0, -1, 0, -1, -1, nd, nb);
        n_cmp++;
        if (bq_tap.size() != exp_q.size()) begin
            n_err++; $display("FAIL stream_count: got %0d beats, expected %0d", bq_tap.size(), exp_q.size());
        end
        for (int i = 0; i < bq_tap.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (bq_tap[i] !== exp_q[i] || bq_data[i] !== bq_exp[i] || bq_last[i] !== (i == exp_q.size() - 1)) begin
                n_err++;
                $display("FAIL stream_beat%0d: got tap %0d data %0h last %0b, expected tap %0d data %0h last %0b",
                         i, bq_tap[i], bq_data[i], bq_last[i], exp_q[i], bq_exp[i], i == exp_q.size() - 1);
            end
        end
        n_cmp++;
        if (bq_data.size() > 0 && bq_data[0] !== 32'h21) begin
            n_err++; $display("FAIL stream_first: got %0h, expected 21", bq_data[0]);
        end
        n_cmp++;
        if (nd !== TAPS + 1) begin n_err++; $display("FAIL stream_done: got cycle %0d, expected %0d", nd, TAPS + 1); end
        n_cmp++;
        if (nb !== TAPS) begin n_err++; $display("FAIL stream_busy: got %0d cycles, expected %0d", nb, TAPS); end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL done_pulse: got %b, expected 0", done); end
    endtask

    task automatic test_backpressure();
        int nd, nb;
        build_exp(1);
        run_stream(1, 2, 4, 3, -1, -1, nd, nb);
        n_cmp++;
        if (sq_tap.size() != 3) begin n_err++; $display("FAIL bp_stalls: got %0d, expected 3", sq_tap.size()); end
        for (int i = 0; i < sq_tap.size(); i++) begin
            n_cmp++;
            if (sq_tap[i] !== 4 || sq_data[i] !== 32'h15) begin
                n_err++; $display("FAIL bp_hold%0d: got tap %0d data %0h, expected tap 4 data 15", i, sq_tap[i], sq_data[i]);
            end
        end
        n_cmp++;
        if (bq_tap.size() != exp_q.size()) begin
            n_err++; $display("FAIL bp_count: got %0d beats, expected %0d", bq_tap.size(), exp_q.size());
        end
        for (int i = 0; i < bq_tap.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (bq_tap[i] !== exp_q[i] || bq_data[i] !== bq_exp[i]) begin
                n_err++; $display("FAIL bp_beat%0d: got tap %0d data %0h, expected tap %0d data %0h",
                                  i, bq_tap[i], bq_data[i], exp_q[i], bq_exp[i]);
            end
        end
        n_cmp++;
        if (nd !== TAPS + 4 || nb !== TAPS + 3) begin
            n_err++; $display("FAIL bp_timing: got done %0d busy %0d, expected done %0d busy %0d", nd, nb, TAPS + 4, TAPS + 3);
        end
    endtask

    task automatic test_illegal();
        bit e;
        int nd, nb;
        write_w(0, 9, 8'h55, e);
        n_cmp++;
        if (e !== 1'b1) begin n_err++; $display("FAIL bad_tap_err: got %b, expected 1", e); end
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b0) begin n_err++; $display("FAIL err_pulse: got %b, expected 0", err); end
        build_exp(0);
        run_stream(0, 0, -1, 0, -1, 3, nd, nb);
        n_cmp++;
        if (err_seen !== 1'b0) begin n_err++; $display("FAIL busy_start_err: got %b, expected 0", err_seen); end
        n_cmp++;
        if (bq_tap.size() != exp_q.size() || nd !== TAPS + 1) begin
            n_err++; $display("FAIL busy_start: got %0d beats done %0d, expected %0d beats done %0d",
                              bq_tap.size(), nd, exp_q.size(), TAPS + 1);
        end
        for (int i = 0; i < bq_tap.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (bq_tap[i] !== exp_q[i] || bq_data[i] !== bq_exp[i]) begin
                n_err++; $display("FAIL unchanged_beat%0d: got tap %0d data %0h, expected tap %0d data %0h",
                                  i, bq_tap[i], bq_data[i], exp_q[i], bq_exp[i]);
            end
        end
        @(posedge clk); #1;
        start3 = 1'b1; ch_sel3 = 2'd3;
        @(posedge clk); #1;
        start3 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({err3, busy3} !== 2'b10) begin n_err++; $display("FAIL bad_ch_start: got err %b busy %b, expected err 1 busy 0", err3, busy3); end
        n_cmp++;
        if ({w_valid3, w_last3, done3, w_data3, w_tap3} !== 15'h0) begin
            n_err++; $display("FAIL bad_ch_outputs: got %h, expected 0", {w_valid3, w_last3, done3, w_data3, w_tap3});
        end
        @(posedge clk); #1;
        wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_tap3 = 4'd0; wr_data3 = 8'h5A;
        @(posedge clk); #1;
        wr_en3 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (err3 !== 1'b1) begin n_err++; $display("FAIL bad_ch_write: got %b, expected 1", err3); end
        @(posedge clk); #1;
        start3 = 1'b1; ch_sel3 = 2'd2;
        @(posedge clk); #1;
        start3 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({err3, busy3} !== 2'b01) begin n_err++; $display("FAIL good_ch_start: got err %b busy %b, expected err 0 busy 1", err3, busy3); end
    endtask

    task automatic test_midwrite();
        wr_t w;
        int nd, nb, d1, d7;
        w.ch = 2; w.tap = 7; w.data = 8'h7F; inj_q.push_back(w);
        w.ch = 2; w.tap = 1; w.data = 8'h99; inj_q.push_back(w);
        build_exp(2);
        run_stream(2, 0, -1, 0, 3, -1, nd, nb);
        d1 = -1; d7 = -1;
        for (int i = 0; i < bq_tap.size(); i++) begin
            if (bq_tap[i] == 1) d1 = bq_data[i];
            if (bq_tap[i] == 7) d7 = bq_data[i];
        end
        n_cmp++;
        if (d1 !== 16 * 2 + 1 + 1) begin n_err++; $display("FAIL midwrite_old: got %0h, expected 22", d1); end
        n_cmp++;
        if (d7 !== 32'h7F) begin n_err++; $display("FAIL midwrite_new: got %0h, expected 7f", d7); end
        n_cmp++;
        if (bq_tap.size() != exp_q.size() || nd !== TAPS + 1) begin
            n_err++; $display("FAIL midwrite_count: got %0d beats done %0d, expected %0d beats done %0d",
                              bq_tap.size(), nd, exp_q.size(), TAPS + 1);
        end
    endtask

    task automatic test_reset_abort();
        bit found = 0;
        bit dn = 0;
        int nd, nb;
        @(posedge clk); #1;
        start = 1'b1; ch_sel = 2'd3; w_ready = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (w_valid && w_tap == 4'd5) begin found = 1; break; end
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL abort_reach: got no tap 5 beat, expected one"); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_model();
        @(negedge clk);
        n_cmp++;
        if ({w_valid, busy, done} !== 3'b000) begin
            n_err++; $display("FAIL abort_state: got valid %b busy %b done %b, expected 000", w_valid, busy, done);
        end
        repeat (4) begin @(negedge clk); if (done) dn = 1; end
        n_cmp++;
        if (dn !== 1'b0) begin n_err++; $display("FAIL abort_done: got done pulse, expected none"); end
        build_exp(3);
        run_stream(3, 0, -1, 0, -1, -1, nd, nb);
        n_cmp++;
        if (bq_tap.size() != exp_q.size() || nd !== TAPS + 1) begin
            n_err++; $display("FAIL cleared_count: got %0d beats done %0d, expected %0d beats done %0d",
                              bq_tap.size(), nd, exp_q.size(), TAPS + 1);
        end
        for (int i = 0; i < bq_tap.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (bq_tap[i] !== exp_q[i] || bq_data[i] !== 0) begin
                n_err++; $display("FAIL cleared_beat%0d: got tap %0d data %0h, expected tap %0d data 0",
                                  i, bq_tap[i], bq_data[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        bit e;
        int nd, nb, ch, tap, v;
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < 14; k++) begin
                ch  = $urandom_range(0, NCH - 1);
                tap = $urandom_range(0, 15);
                v   = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255);
                write_w(ch, tap, v, e);
                n_cmp++;
                if (e !== (tap >= TAPS)) begin
                    n_err++; $display("FAIL rand_wr_err: tap %0d got err %b, expected %b", tap, e, tap >= TAPS);
                end
            end
            ch = $urandom_range(0, NCH - 1);
            build_exp(ch);
            run_stream(ch, 1, -1, 0, -1, -1, nd, nb);
            n_cmp++;
            if (bq_tap.size() != exp_q.size() || nd < 0) begin
                n_err++; $display("FAIL rand_count: ch %0d got %0d beats done %0d, expected %0d beats and a done",
                                  ch, bq_tap.size(), nd, exp_q.size());
            end
            for (int i = 0; i < bq_tap.size() && i < exp_q.size(); i++) begin
                n_cmp++;
                if (bq_tap[i] !== exp_q[i] || bq_data[i] !== bq_exp[i] || bq_last[i] !== (i == exp_q.size() - 1)) begin
                    n_err++;
                    $display("FAIL rand_beat%0d: got tap %0d data %0h last %0b, expected tap %0d data %0h last %0b",
                             i, bq_tap[i], bq_data[i], bq_last[i], exp_q[i], bq_exp[i], i == exp_q.size() - 1);
                end
            end
`ifndef CONV_WSEQ_ZERO_SKIP_EN
            if (bq_cyc.size() > 0) begin
                n_cmp++;
                if (nd !== bq_cyc[bq_cyc.size() - 1] + 1) begin
                    n_err++; $display("FAIL rand_done: got cycle %0d, expected %0d", nd, bq_cyc[bq_cyc.size() - 1] + 1);
                end
            end
`endif
        end
    endtask

`ifdef CONV_WSEQ_ZERO_SKIP_EN
    task automatic test_zero_skip();
        bit e;
        int nd, nb;
        int k0 [TAPS] = '{1, 0, 0, 4, 0, 0, 0, 8, 0};
        int want [3]  = '{0, 3, 7};
        for (int t = 0; t < TAPS; t++) begin
            write_w(0, t, k0[t], e);
            write_w(1, t, 0, e);
        end
        run_stream(0, 0, -1, 0, -1, -1, nd, nb);
        n_cmp++;
        if (bq_tap.size() != 3) begin n_err++; $display("FAIL skip_count: got %0d beats, expected 3", bq_tap.size()); end
        for (int i = 0; i < bq_tap.size() && i < 3; i++) begin
            n_cmp++;
            if (bq_tap[i] !== want[i] || bq_data[i] !== k0[want[i]] || bq_last[i] !== (i == 2)) begin
                n_err++; $display("FAIL skip_beat%0d: got tap %0d data %0h last %0b, expected tap %0d data %0h last %0b",
                                  i, bq_tap[i], bq_data[i], bq_last[i], want[i], k0[want[i]], i == 2);
            end
        end
        n_cmp++;
        if (nd !== TAPS + 1) begin n_err++; $display("FAIL skip_done: got %0d, expected %0d", nd, TAPS + 1); end
        run_stream(1, 0, -1, 0, -1, -1, nd, nb);
        n_cmp++;
        if (bq_tap.size() != 0 || nd !== TAPS + 1) begin
            n_err++; $display("FAIL skip_allzero: got %0d beats done %0d, expected 0 beats done %0d", bq_tap.size(), nd, TAPS + 1);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_tap = '0; wr_data = '0;
        start = 1'b0; ch_sel = '0; w_ready = 1'b1;
        start3 = 1'b0; ch_sel3 = '0; wr_en3 = 1'b0; wr_ch3 = '0; wr_tap3 = '0; wr_data3 = '0;
        test_reset();
        test_load();
        test_stream();
        test_backpressure();
        test_illegal();
        test_midwrite();
        test_reset_abort();
        test_random();
`ifdef CONV_WSEQ_ZERO_SKIP_EN
        test_zero_skip();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
